// File: rtl/div_seq_unit.sv
// Sequential 8-bit restoring divider: 8 CALC cycles per operation, valid/ready on both sides.
// Optional divide-by-zero fast path is enabled by defining DIV_SEQ_DBZ_CHECK_EN.
module div_seq_unit (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] dividend_i,
  input  logic [7:0] divisor_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] quot_o,
  output logic [7:0] rem_o,
  output logic       dbz_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] q;
  logic [8:0] r;
  logic [2:0] cnt;
  logic [8:0] t;
  logic [9:0] diff;
  logic       borrow;
  logic       div_zero;

  // One restoring step: bring in the next dividend bit, try subtracting the divisor.
  assign t      = {r[7:0], a[7]};
  assign diff   = {1'b0, t} - {2'b00, b};
  assign borrow = diff[9];

`ifdef DIV_SEQ_DBZ_CHECK_EN
  logic dbz;
  assign div_zero = (divisor_i == 8'd0);
  assign dbz_o    = dbz;
`else
  assign div_zero = 1'b0;
  assign dbz_o    = 1'b0;
`endif

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign quot_o      = q;
  assign rem_o       = r[7:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid_i) state_nxt = div_zero ? DONE : CALC;
      CALC: if (cnt == 3'd0) state_nxt = DONE;
      DONE: if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a   <= 8'd0;
      b   <= 8'd0;
      q   <= 8'd0;
      r   <= 9'd0;
      cnt <= 3'd0;
`ifdef DIV_SEQ_DBZ_CHECK_EN
      dbz <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            a   <= dividend_i;
            b   <= divisor_i;
            q   <= 8'd0;
            r   <= 9'd0;
            cnt <= 3'd7;
`ifdef DIV_SEQ_DBZ_CHECK_EN
            dbz <= div_zero;
            if (div_zero) begin
              q   <= 8'hFF;
              r   <= {1'b0, dividend_i};
              cnt <= 3'd0;
            end
`endif
          end
        end
        CALC: begin
          r <= borrow ? t : diff[8:0];
          q <= {q[6:0], ~borrow};
          a <= {a[6:0], 1'b0};
          if (cnt != 3'd0) cnt <= cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_seq_unit.md
DIV_SEQ_UNIT -- requirements
Module: div_seq_unit

Interface
- REQ-001: The block SHALL have one clock and one reset; reset is synchronous and active-high.
- REQ-002: clk_i  input  1  clock; all state updates on rising edge.
- REQ-003: rst_i  input  1  synchronous active-high reset.
- REQ-004: in_valid_i  input  1  operand pair valid.
- REQ-005: in_ready_o  output  1  block can accept operands; high only in IDLE.
- REQ-006: dividend_i  input  8  unsigned dividend.
- REQ-007: divisor_i  input  8  unsigned divisor.
- REQ-008: out_valid_o  output  1  result valid; high only in DONE.
- REQ-009: out_ready_i  input  1  consumer accepts result.
- REQ-010: quot_o  output  8  unsigned quotient.
- REQ-011: rem_o  output  8  unsigned remainder.
- REQ-012: dbz_o  output  1  divide-by-zero flag, valid with out_valid_o.

Function
- REQ-013: The FSM SHALL have states IDLE, CALC, DONE only.
- REQ-014: IDLE->CALC on in_valid_i & in_ready_o: capture dividend into shift register A, divisor into B, clear 9-bit partial remainder R, clear quotient Q, load step counter with 7.
- REQ-015: Each CALC cycle: T = {R[7:0], A[7]}; D = T - {1'b0,B} (9-bit borrow-ripple); no borrow -> R=D, shift 1 into Q LSB; borrow -> R=T, shift 0 into Q LSB; A shifts left by 1.
- REQ-016: CALC SHALL last exactly 8 cycles; counter decrements from 7; CALC->DONE on the step with counter==0.
- REQ-017: Latency: accept edge at cycle 0, out_valid_o high from cycle 9; quot_o=Q, rem_o=R[7:0].
- REQ-018: DONE->IDLE on out_ready_i; quot_o, rem_o, dbz_o SHALL hold stable while out_valid_o=1 and out_ready_i=0.
- REQ-019: in_valid_i SHALL be ignored outside IDLE; no operand queueing.
- REQ-020: Transfer completing in DONE makes in_ready_o high the next cycle; no same-cycle accept in DONE.
- REQ-021: R SHALL never exceed 9 bits; R[8] after any step SHALL be 0 in a correct implementation.
- REQ-022: Divisor 1 and divisor > dividend SHALL need no special path; they follow REQ-015.

Reset
- REQ-023: rst_i SHALL force IDLE, in_ready_o=1, out_valid_o=0, quot_o=0, rem_o=0, dbz_o=0, counter=0, A=B=R=Q=0.
- REQ-024: rst_i in CALC or DONE SHALL abort the operation; no result is produced for it.
- REQ-025: rst_i SHALL take priority over in_valid_i and out_ready_i in the same cycle.

Configuration
- REQ-026: Macro DIV_SEQ_DBZ_CHECK_EN SHALL control the divide-by-zero fast path.
- REQ-027: With DIV_SEQ_DBZ_CHECK_EN defined: accept with divisor_i==0 goes IDLE->DONE directly; quot_o=0xFF, rem_o=dividend, dbz_o=1; out_valid_o from cycle 1.
- REQ-028: Without it: divisor 0 runs 8 CALC cycles per REQ-015 (yields quot_o=0xFF, rem_o=dividend); dbz_o tied 0; no compare logic synthesized.

Verification
- REQ-029: dividend 200, divisor 7, out_ready_i=1 -> out_valid_o at cycle 9, quot_o=0x1C, rem_o=0x04, dbz_o=0.
- REQ-030: 255/1 then 5/9 back-to-back -> quot 0xFF rem 0x00, then quot 0x00 rem 0x05; in_ready_o low cycles 1-9 of each op.
- REQ-031: 100/10 with out_ready_i=0 for 5 cycles after valid -> quot_o=0x0A, rem_o=0x00 held stable; IDLE one cycle after out_ready_i=1.
- REQ-032: 0x37/0 -> with DIV_SEQ_DBZ_CHECK_EN: valid at cycle 1, quot 0xFF, rem 0x37, dbz 1; without: valid at cycle 9, same quot/rem, dbz 0.
- REQ-033: rst_i asserted at cycle 4 of 200/7 -> next cycle IDLE, in_ready_o=1, out_valid_o=0, all outputs 0; a following 9/3 returns quot 0x03 rem 0x00.
- REQ-034: in_valid_i toggled with new operands during CALC -> ignored; result matches first-captured operands.
